// File: rtl/pipeline_stage_skid_if.sv
// Valid/ready handshake bundle carrying one instruction (control bits plus payload).
// The producer uses the master modport and the consumer uses the slave modport.
interface pipeline_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipeline_stage_skid.sv
// Elastic pipeline stage with a main slot (M) and an optional skid slot (S).
// With SKID_EN=1, ready is a pure register output. With SKID_EN=0, the stage is a
// single slot whose ready passes the downstream ready through combinationally.
// Control bits read as zero whenever the stage output is invalid. The payload holds
// its last value. Flush kills every held entry and any incoming entry.
module pipeline_stage_skid #(
  parameter int          DATA_W  = 32,
  parameter int          CTRL_W  = 8,
  parameter int unsigned SKID_EN = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_stage_skid_if.slave   up,
  pipeline_stage_skid_if.master  dn,
  input  logic                   flush_i,
  output logic [1:0]             occupancy_o,
  output logic [7:0]             flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HALF,
    ST_FULL
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [1:0]        occ_q, occ_d;
  logic [7:0]        flush_cnt_q, flush_cnt_d;

  logic              m_valid;
  logic              s_valid;
  logic              ready;
  logic              accept;
  logic              emit;
  logic              kill_m;
  logic [8:0]        cnt_sum;

  // Slot valid flags decoded from the state, and the handshake qualifiers
  always_comb begin
    m_valid = (state_q != ST_EMPTY);
    s_valid = (state_q == ST_FULL);
    if (SKID_EN != 0) ready = ~s_valid;
    else              ready = dn.ready | ~m_valid;
    accept  = up.valid & ready;
    emit    = m_valid & dn.ready;
  end

  assign up.ready    = ready;
  assign dn.valid    = m_valid;
  assign dn.ctrl     = m_valid ? m_ctrl_q : '0;
  assign dn.data     = m_data_q;
  assign occupancy_o = occ_q;
  assign flush_cnt_o = flush_cnt_q;

  // Next state, slot loads and flush accounting; flush overrides all transfers
  always_comb begin
    state_d     = state_q;
    m_data_d    = m_data_q;
    m_ctrl_d    = m_ctrl_q;
    s_data_d    = s_data_q;
    s_ctrl_d    = s_ctrl_q;
    flush_cnt_d = flush_cnt_q;
    occ_d       = occ_q;
    kill_m      = m_valid & ~emit;
    cnt_sum     = {1'b0, flush_cnt_q} + {8'd0, kill_m} + {8'd0, s_valid};

    if (flush_i) begin
      state_d     = ST_EMPTY;
      flush_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d  = ST_HALF;
            m_data_d = up.data;
            m_ctrl_d = up.ctrl;
          end
        end
        ST_HALF: begin
          if (accept && emit) begin
            m_data_d = up.data;
            m_ctrl_d = up.ctrl;
          end else if (accept && (SKID_EN != 0)) begin
            state_d  = ST_FULL;
            s_data_d = up.data;
            s_ctrl_d = up.ctrl;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_d  = ST_HALF;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    unique case (state_d)
      ST_HALF: occ_d = 2'd1;
      ST_FULL: occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // State and slot registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      s_data_q    <= '0;
      s_ctrl_q    <= '0;
      occ_q       <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      s_data_q    <= s_data_d;
      s_ctrl_q    <= s_ctrl_d;
      occ_q       <= occ_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
